// File: rtl/gpr_file_sb.sv
// Parametrised register file with write-to-read bypass, optional hardwired zero
// register and a per-register busy scoreboard for the issue stage.
module gpr_file_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write_en,
  input  logic [ADDR_W-1:0] reg_write_dest,
  input  logic [DATA_W-1:0] reg_write_data,
  input  logic [ADDR_W-1:0] reg_read_addr_1,
  output logic [DATA_W-1:0] reg_read_data_1,
  input  logic [ADDR_W-1:0] reg_read_addr_2,
  output logic [DATA_W-1:0] reg_read_data_2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy_1,
  output logic              busy_2,
  output logic              rsv_conflict,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     pending_cnt_q, pending_cnt_d;
  logic                wr_ok, rsv_ok;
  logic                hit_1, hit_2, zero_1, zero_2;

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  always_comb begin
    wr_ok  = reg_write_en && !is_zero(reg_write_dest);
    rsv_ok = rsv_en && !is_zero(rsv_addr);
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[reg_write_dest] = reg_write_data;
      busy_d[reg_write_dest] = 1'b0;
    end
    // Reservation applied after the write so a new producer wins over writeback.
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
    pending_cnt_d = pending_cnt_q;
    if (rsv_ok && !busy_q[rsv_addr]) begin
      pending_cnt_d = pending_cnt_d + 1'b1;
    end
    if (wr_ok && busy_q[reg_write_dest] && !(rsv_ok && (rsv_addr == reg_write_dest))) begin
      pending_cnt_d = pending_cnt_d - 1'b1;
    end
  end

  always_comb begin
    zero_1 = is_zero(reg_read_addr_1);
    zero_2 = is_zero(reg_read_addr_2);
    hit_1  = (BYPASS != 0) && wr_ok && (reg_write_dest == reg_read_addr_1);
    hit_2  = (BYPASS != 0) && wr_ok && (reg_write_dest == reg_read_addr_2);
    reg_read_data_1 = hit_1 ? reg_write_data : (zero_1 ? '0 : regs_q[reg_read_addr_1]);
    reg_read_data_2 = hit_2 ? reg_write_data : (zero_2 ? '0 : regs_q[reg_read_addr_2]);
    busy_1 = busy_q[reg_read_addr_1] && !hit_1 && !zero_1;
    busy_2 = busy_q[reg_read_addr_2] && !hit_2 && !zero_2;
    rsv_conflict = rsv_en && busy_q[rsv_addr] &&
                   !(reg_write_en && (reg_write_dest == rsv_addr));
  end

  assign pending_cnt = pending_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

endmodule

// File: tb/tb_gpr_file_sb.sv
// Bench for gpr_file_sb: a default instance (ZERO_REG=0, BYPASS=1) and a
// ZERO_REG=1, BYPASS=0 instance share stimulus; checked by table, sequences and a model.
module tb_gpr_file_sb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we;
  logic [2:0] dest;
  logic [7:0] wdata;
  logic [2:0] ra1, ra2;
  logic       re;
  logic [2:0] raddr;

  logic [7:0] m_rd1, m_rd2, z_rd1, z_rd2;
  logic       m_b1, m_b2, m_conf, z_b1, z_b2, z_conf;
  logic [3:0] m_cnt, z_cnt;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  gpr_file_sb u_dut_m (
    .clk(clk), .rst_n(rst_n),
    .reg_write_en(we), .reg_write_dest(dest), .reg_write_data(wdata),
    .reg_read_addr_1(ra1), .reg_read_data_1(m_rd1),
    .reg_read_addr_2(ra2), .reg_read_data_2(m_rd2),
    .rsv_en(re), .rsv_addr(raddr),
    .busy_1(m_b1), .busy_2(m_b2), .rsv_conflict(m_conf), .pending_cnt(m_cnt)
  );

  gpr_file_sb #(.ZERO_REG(1), .BYPASS(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n),
    .reg_write_en(we), .reg_write_dest(dest), .reg_write_data(wdata),
    .reg_read_addr_1(ra1), .reg_read_data_1(z_rd1),
    .reg_read_addr_2(ra2), .reg_read_data_2(z_rd2),
    .rsv_en(re), .rsv_addr(raddr),
    .busy_1(z_b1), .busy_2(z_b2), .rsv_conflict(z_conf), .pending_cnt(z_cnt)
  );

  // Reference state: index 0 models the default instance, index 1 the zero/no-bypass one.
  logic [7:0] mdl_mem  [2][8];
  bit         mdl_busy [2][8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic bit zr(input int c, input logic [2:0] a);
    return (c == 1) && (a == 3'd0);
  endfunction

  function automatic bit fwd(input int c, input logic [2:0] a);
    return (c == 0) && we && (dest == a);
  endfunction

  function automatic logic [7:0] exp_rd(input int c, input logic [2:0] a);
    if (fwd(c, a)) return wdata;
    if (zr(c, a)) return 8'h00;
    return mdl_mem[c][a];
  endfunction

  function automatic logic exp_busy(input int c, input logic [2:0] a);
    return mdl_busy[c][a] && !fwd(c, a) && !zr(c, a);
  endfunction

  function automatic logic exp_conf(input int c);
    return re && mdl_busy[c][raddr] && !(we && dest == raddr);
  endfunction

  function automatic logic [3:0] exp_cnt(input int c);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(mdl_busy[c][i]);
    return 4'(n);
  endfunction

  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      if (we && !zr(c, dest)) begin
        mdl_mem[c][dest]  = wdata;
        mdl_busy[c][dest] = 1'b0;
      end
      if (re && !zr(c, raddr)) mdl_busy[c][raddr] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 8; i++) begin
        mdl_mem[c][i]  = 8'h00;
        mdl_busy[c][i] = 1'b0;
      end
  endtask

  task automatic drive(input logic w, input logic [2:0] d, input logic [7:0] wd,
                       input logic [2:0] r1, input logic [2:0] r2,
                       input logic e, input logic [2:0] a);
    we = w; dest = d; wdata = wd; ra1 = r1; ra2 = r2; re = e; raddr = a;
  endtask

  task automatic check_model();
    chk("rd1_m",  m_rd1,  exp_rd(0, ra1));
    chk("rd2_m",  m_rd2,  exp_rd(0, ra2));
    chk("busy1_m", m_b1,  exp_busy(0, ra1));
    chk("busy2_m", m_b2,  exp_busy(0, ra2));
    chk("conf_m", m_conf, exp_conf(0));
    chk("cnt_m",  m_cnt,  exp_cnt(0));
    chk("rd1_z",  z_rd1,  exp_rd(1, ra1));
    chk("rd2_z",  z_rd2,  exp_rd(1, ra2));
    chk("busy1_z", z_b1,  exp_busy(1, ra1));
    chk("busy2_z", z_b2,  exp_busy(1, ra2));
    chk("conf_z", z_conf, exp_conf(1));
    chk("cnt_z",  z_cnt,  exp_cnt(1));
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 3'd0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       w;
    logic [2:0] d;
    logic [7:0] wd;
    logic [2:0] r1, r2;
    logic       e;
    logic [2:0] a;
    logic [7:0] e_rd1, e_rd2;
    logic       e_b1, e_b2, e_conf;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // Expected values hold during the cycle, before that cycle's edge.
    tbl[0]  = '{1'b1, 3'd5, 8'h3C, 3'd5, 3'd5, 1'b0, 3'd0, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd5, 1'b0, 3'd0, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[2]  = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd5, 1'b1, 3'd2, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[3]  = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd5, 1'b0, 3'd0, 8'h00, 8'h3C, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[4]  = '{1'b1, 3'd2, 8'h11, 3'd2, 3'd2, 1'b0, 3'd0, 8'h11, 8'h11, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[5]  = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd5, 1'b0, 3'd0, 8'h11, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[6]  = '{1'b0, 3'd0, 8'h00, 3'd4, 3'd6, 1'b1, 3'd4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[7]  = '{1'b0, 3'd0, 8'h00, 3'd4, 3'd6, 1'b1, 3'd6, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[8]  = '{1'b1, 3'd4, 8'h77, 3'd4, 3'd6, 1'b1, 3'd4, 8'h77, 8'h00, 1'b0, 1'b1, 1'b0, 4'd2};
    tbl[9]  = '{1'b0, 3'd0, 8'h00, 3'd4, 3'd6, 1'b1, 3'd6, 8'h77, 8'h00, 1'b1, 1'b1, 1'b1, 4'd2};
    tbl[10] = '{1'b0, 3'd0, 8'h00, 3'd4, 3'd6, 1'b0, 3'd0, 8'h77, 8'h00, 1'b1, 1'b1, 1'b0, 4'd2};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 1'b0, 3'd0);
    model_reset();
    #2;
    chk("rst_rd1_m", m_rd1, 8'h00);
    chk("rst_rd2_m", m_rd2, 8'h00);
    chk("rst_busy_m", m_b1, 1'b0);
    chk("rst_cnt_m", m_cnt, 4'd0);
    chk("rst_cnt_z", z_cnt, 4'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven vectors on the default instance
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].w, tbl[i].d, tbl[i].wd, tbl[i].r1, tbl[i].r2, tbl[i].e, tbl[i].a);
      @(negedge clk);
      chk($sformatf("tbl%0d_rd1", i),  m_rd1,  tbl[i].e_rd1);
      chk($sformatf("tbl%0d_rd2", i),  m_rd2,  tbl[i].e_rd2);
      chk($sformatf("tbl%0d_b1", i),   m_b1,   tbl[i].e_b1);
      chk($sformatf("tbl%0d_b2", i),   m_b2,   tbl[i].e_b2);
      chk($sformatf("tbl%0d_conf", i), m_conf, tbl[i].e_conf);
      chk($sformatf("tbl%0d_cnt", i),  m_cnt,  tbl[i].e_cnt);
      finish_cycle();
    end

    // Reset asserted between edges
    drive(1'b1, 3'd3, 8'hA5, 3'd3, 3'd3, 1'b1, 3'd1);
    finish_cycle();
    drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 1'b0, 3'd0);
    @(negedge clk);
    chk("pre_rst_rd1", m_rd1, 8'hA5);
    chk("pre_rst_cnt", m_cnt, 4'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd1", m_rd1, 8'h00);
    chk("mid_rst_cnt", m_cnt, 4'd0);
    chk("mid_rst_rd1_z", z_rd1, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Zero register and no-bypass behaviour on the second instance
    drive(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 1'b1, 3'd0);
    finish_cycle();
    drive(1'b1, 3'd5, 8'h3C, 3'd0, 3'd5, 1'b0, 3'd0);
    @(negedge clk);
    chk("zr_rd1_z", z_rd1, 8'h00);
    chk("zr_busy1_z", z_b1, 1'b0);
    chk("zr_cnt_z", z_cnt, 4'd0);
    chk("zr_rd1_m", m_rd1, 8'hFF);
    chk("zr_cnt_m", m_cnt, 4'd1);
    chk("nobyp_rd2_z", z_rd2, 8'h00);
    chk("byp_rd2_m", m_rd2, 8'h3C);
    finish_cycle();
    drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd5, 1'b0, 3'd0);
    @(negedge clk);
    chk("nobyp_next_z", z_rd1, 8'h3C);
    finish_cycle();

    // Full scoreboard, saturation and no underflow
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'd0, 8'h00, 3'(i), 3'd0, 1'b1, 3'(i));
      finish_cycle();
    end
    drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd0, 1'b1, 3'd3);
    @(negedge clk);
    chk("full_cnt_m", m_cnt, 4'd8);
    chk("full_cnt_z", z_cnt, 4'd7);
    chk("full_conf_m", m_conf, 1'b1);
    chk("full_busy1_m", m_b1, 1'b1);
    chk("full_busy2_z", z_b2, 1'b0);
    finish_cycle();
    drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd0, 1'b0, 3'd0);
    @(negedge clk);
    chk("sat_cnt_m", m_cnt, 4'd8);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 8'(8'h10 + i), 3'd0, 3'd0, 1'b0, 3'd0);
      finish_cycle();
    end
    drive(1'b1, 3'd1, 8'h99, 3'd1, 3'd0, 1'b0, 3'd0);
    @(negedge clk);
    chk("clr_cnt_m", m_cnt, 4'd0);
    chk("clr_cnt_z", z_cnt, 4'd0);
    finish_cycle();
    drive(1'b0, 3'd0, 8'h00, 3'd1, 3'd7, 1'b0, 3'd0);
    @(negedge clk);
    chk("nounder_cnt_m", m_cnt, 4'd0);
    chk("nounder_rd1_m", m_rd1, 8'h99);
    chk("nounder_rd2_m", m_rd2, 8'h17);
    finish_cycle();

    // Randomised traffic against the reference model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) begin
        dest = raddr;
        ra1  = raddr;
      end
      @(negedge clk);
      check_model();
      finish_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
